// File: rtl/mdu_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Raises stall_req while busy so execute holds dependent instructions.
module mdu_hilo_unit #(
  parameter int DW = 32,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [DW-1:0] src_a,
  input  logic [DW-1:0] src_b,
  input  logic          we_hi,
  input  logic          we_lo,
  input  logic [DW-1:0] wd,
  input  logic          rd_en,
  input  logic          rd_sel,
  output logic          busy,
  output logic          stall_req,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo,
  output logic [DW-1:0] rd_data
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            div_q, div_d;
  logic            neg_q, neg_d;
  logic            negr_q, negr_d;
  logic            dz_q, dz_d;
  logic [DW-1:0]   m_q, m_d;
  logic [2*DW-1:0] acc_q, acc_d;
  logic [DW-1:0]   hi_q, hi_d;
  logic [DW-1:0]   lo_q, lo_d;

  logic [DW-1:0]   a_mag, b_mag;
  logic [DW:0]     sum, shl, diff;
  logic [2*DW-1:0] pneg;
  logic [DW-1:0]   qneg, rneg;

  assign a_mag = (op[0] && src_a[DW-1]) ? -src_a : src_a;
  assign b_mag = (op[0] && src_b[DW-1]) ? -src_b : src_b;

  assign sum  = {1'b0, acc_q[2*DW-1:DW]} + {1'b0, m_q};
  assign shl  = {acc_q[2*DW-1:DW], acc_q[DW-1]};
  assign diff = shl - {1'b0, m_q};
  assign pneg = -acc_q;
  assign qneg = -acc_q[DW-1:0];
  assign rneg = -acc_q[2*DW-1:DW];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    m_d     = m_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          div_d   = op[1];
          neg_d   = op[0] & (src_a[DW-1] ^ src_b[DW-1]);
          negr_d  = op[0] & src_a[DW-1];
          dz_d    = op[1] & (src_b == '0);
          // Divide: acc = {rem, dividend}; multiply: acc = {0, multiplier}
          m_d     = op[1] ? b_mag : a_mag;
          acc_d   = {{DW{1'b0}}, op[1] ? a_mag : b_mag};
        end else begin
          if (we_hi) hi_d = wd;
          if (we_lo) lo_d = wd;
        end
      end
      RUN: begin
        if (div_q) begin
          if (shl >= {1'b0, m_q})
            acc_d = {diff[DW-1:0], acc_q[DW-2:0], 1'b1};
          else
            acc_d = {shl[DW-1:0], acc_q[DW-2:0], 1'b0};
        end else if (acc_q[0]) begin
          acc_d = {sum, acc_q[DW-1:1]};
        end else begin
          acc_d = {1'b0, acc_q[2*DW-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DW - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        if (div_q) begin
          hi_d = negr_q ? rneg : acc_q[2*DW-1:DW];
          lo_d = dz_q ? '1 : (neg_q ? qneg : acc_q[DW-1:0]);
        end else begin
          {hi_d, lo_d} = neg_q ? pneg : acc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      m_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign stall_req = busy & (start | rd_en | we_hi | we_lo);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign rd_data   = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// Self-checking bench for mdu_hilo_unit: vector table, corner
// sequences and random operations against an arithmetic model.
module tb_mdu_hilo_unit;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0;
  logic [1:0]  op = 0;
  logic [31:0] src_a = 0, src_b = 0, wd = 0;
  logic        we_hi = 0, we_lo = 0, rd_en = 0, rd_sel = 0;
  logic        busy, stall_req;
  logic [31:0] hi, lo, rd_data;

  int passed = 0;
  int total  = 0;

  mdu_hilo_unit #(.DW(32), .CW(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .we_hi(we_hi), .we_lo(we_lo),
    .wd(wd), .rd_en(rd_en), .rd_sel(rd_sel), .busy(busy),
    .stall_req(stall_req), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Returns {hi, lo} from plain arithmetic on the architectural rules
  function automatic logic [63:0] model(input logic [1:0] o,
                                        input logic [31:0] a, b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = '0;
    case (o)
      2'd0: p = {32'b0, a} * {32'b0, b};
      2'd1: p = 64'(sa * sb);
      2'd2: p = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      default:
        if (b == 0) p = {a, 32'hFFFFFFFF};
        else p = {32'(sa % sb), 32'(sa / sb)};
    endcase
    return p;
  endfunction

  task automatic run_op(input string nm, input logic [1:0] o,
                        input logic [31:0] a, b, eh, el);
    int bc;
    op = o; src_a = a; src_b = b; start = 1;
    @(posedge clk); #1;
    start = 0;
    src_a = $urandom; src_b = $urandom;
    bc = 0;
    while (busy && bc < 100) begin
      bc++;
      @(posedge clk); #1;
    end
    chk({nm, " busy"}, 64'(bc), 64'd33);
    chk({nm, " hi"}, {32'b0, hi}, {32'b0, eh});
    chk({nm, " lo"}, {32'b0, lo}, {32'b0, el});
  endtask

  vec_t vt[7];

  initial begin
    int sc;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic [63:0] e;

    vt[0] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1};
    vt[1] = '{2'd1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vt[2] = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0};
    vt[3] = '{2'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[4] = '{2'd2, 32'd100, 32'd7, 32'd2, 32'd14};
    vt[5] = '{2'd2, 32'd100, 32'd0, 32'h64, 32'hFFFFFFFF};
    vt[6] = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000};

    #12;
    chk("reset busy", {63'b0, busy}, 64'd0);
    chk("reset hi", {32'b0, hi}, 64'd0);
    chk("reset lo", {32'b0, lo}, 64'd0);
    rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b,
             vt[i].hi, vt[i].lo);

    // MTHI+MTLO together, then read both through rd_data
    we_hi = 1; we_lo = 1; wd = 32'hA5A5A5A5;
    @(posedge clk); #1;
    we_hi = 0; we_lo = 0;
    rd_sel = 1; #1;
    chk("mt both hi", {32'b0, rd_data}, 64'hA5A5A5A5);
    rd_sel = 0; #1;
    chk("mt both lo", {32'b0, rd_data}, 64'hA5A5A5A5);

    // MFHI hazard plus ignored MTLO while busy
    op = 2'd2; src_a = 32'd100; src_b = 32'd7; start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    rd_en = 1; rd_sel = 1; we_lo = 1; wd = 32'h1234;
    #1;
    sc = 0;
    while (stall_req && sc < 100) begin
      sc++;
      @(posedge clk); #1;
    end
    chk("stall cycles", 64'(sc), 64'd32);
    chk("stall busy off", {63'b0, busy}, 64'd0);
    chk("mfhi new", {32'b0, rd_data}, 64'd2);
    chk("mtlo ignored", {32'b0, lo}, 64'd14);
    rd_en = 0; we_lo = 0; rd_sel = 0;
    @(posedge clk); #1;

    // start wins over a same-cycle MTHI
    we_hi = 1; wd = 32'hDEADBEEF;
    run_op("start+mthi", 2'd0, 32'd3, 32'd5, 32'd0, 32'd15);
    we_hi = 0;

    // Async reset mid-run
    op = 2'd0; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (10) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst busy", {63'b0, busy}, 64'd0);
    chk("rst hi", {32'b0, hi}, 64'd0);
    chk("rst lo", {32'b0, lo}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    run_op("post-rst", 2'd0, 32'd3, 32'd5, 32'd0, 32'd15);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 20);
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h80000000;
      e = model(ro, ra, rb);
      run_op($sformatf("rnd%0d op%0d %h %h", i, ro, ra, rb),
             ro, ra, rb, e[63:32], e[31:0]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mdu_hilo_unit.md
Name: mdu_hilo_unit

Overview:
- Iterative multiply/divide unit with the HI/LO architectural registers.
- Consumes execute-stage operands and HI/LO control, producing MULT/MULTU/DIV/DIVU results in HI/LO.
- Returns a stall request upstream, so the pipeline holds the decode/execute registers while the unit is busy.
- Sits beside the ALU in execute. Supplies the MFHI/MFLO read data that the execute stage muxes in.

Parameters:
- DW, 32: operand and HI/LO width.
- CW, 6: iteration-counter width; must satisfy 2^CW > DW.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  launch a mult/div operation this cycle.
- op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- src_a  in  DW  rs value (multiplicand / dividend).
- src_b  in  DW  rt value (multiplier / divisor).
- we_hi  in  1  MTHI write enable.
- we_lo  in  1  MTLO write enable.
- wd  in  DW  MTHI/MTLO write data.
- rd_en  in  1  MFHI/MFLO read in execute this cycle.
- rd_sel  in  1  read select: 0 LO, 1 HI.
- busy  out  1  operation in flight.
- stall_req  out  1  hold upstream pipeline registers.
- hi  out  DW  HI register.
- lo  out  DW  LO register.
- rd_data  out  DW  combinational: rd_sel ? hi : lo.

Behaviour:
- Reset (rst_n low, asynchronous, dominates everything):
  - state=IDLE; busy=0; hi=0; lo=0; counter=0; all datapath registers cleared.
  - Reset asserted mid-operation aborts it. No partial write to HI/LO.
- States:
  - IDLE -> RUN on a rising edge with start=1.
  - RUN -> FIX when the counter reaches DW-1 (exactly DW edges in RUN).
  - FIX -> IDLE after one edge.
- Launch edge:
  - Latch op.
  - Latch operand magnitudes: absolute value for signed ops (op[0]=1), raw value otherwise.
  - Latch the result-sign flags.
  - counter=0; busy=1 from this edge.
- Multiply: radix-2 shift-add, one multiplier bit per RUN cycle, into a 2*DW accumulator.
- Divide: restoring shift-subtract, one quotient bit per RUN cycle; quotient and remainder each DW bits.
- FIX edge:
  - Apply sign fixups.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - Write hi/lo: product upper/lower half, or remainder/quotient.
  - busy=0 after this edge.
- Latency: start sampled at edge N; busy high for edges N..N+32 (33 cycles); hi/lo hold new values after edge N+33.
- Divide by zero (src_b=0, DIV or DIVU): HI=src_a, LO=all ones. Same latency, no exception.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- stall_req = busy & (start | rd_en | we_hi | we_lo).
  - The pipeline holds the requesting instruction until busy falls; the request is then accepted on the following edge.
- Any start, we_hi or we_lo while busy: ignored, no state change.
- IDLE priority:
  - start with we_hi/we_lo in the same cycle: start wins, writes dropped.
  - we_hi and we_lo together: both written from wd.
- rd_data reflects hi/lo combinationally. An MTHI/MTLO written at edge E is visible to a read after E.
- Operands are sampled only at launch; later changes on src_a/src_b have no effect.

Test Plan:
1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy high exactly 33 cycles; then HI=0xFFFFFFFE, LO=0x00000001.
2. MULT 0xFFFFFFFD(-3)*7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
3. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2.
4. DIVU 100/0 -> HI=0x64, LO=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
5. Hazard and priority:
   - rd_en=1, rd_sel=1 held from the cycle after a start -> stall_req=1 for 32 cycles, then 0.
   - rd_data shows the new HI once busy=0.
   - we_lo with wd=0x1234 while busy -> LO unchanged.
   - start + we_hi in IDLE -> HI gets the op result, not wd.
6. Reset:
   - rst_n low at RUN cycle 10 -> busy=0, hi=lo=0 immediately, without a clock.
   - After release, MULTU 3*5 -> LO=15, HI=0 with normal 33-cycle busy.
